// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the seq_mul_shift_add multiplier and its scoreboard.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Cycles from accept to done: k = (index of top set bit of |b|) + 1, or 1 for a zero operand.
  function automatic int expected_latency(input logic [31:0] a_mag, input logic [31:0] b_mag);
    int lat;
    lat = 0;
    if (a_mag == '0 || b_mag == '0) return 1;
    for (int i = 0; i < 32; i++) begin
      if (b_mag[i]) lat = i + 1;
    end
    return lat;
  endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// Handshake FSM for seq_mul_shift_add: IDLE -> RUN -> DONE with early exit and abort.
module seq_mul_ctrl
  import seq_mul_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic zero_op,
  input  logic last,
  output logic ready,
  output logic busy,
  output logic done,
  output logic load,
  output logic step,
  output logic finish
);

  state_t state;

  // ready is high exactly in IDLE/DONE and busy exactly in RUN, so they double as state decodes.
  assign load   = start && ready;
  assign step   = busy && !abort;
  assign finish = (load && zero_op) || (step && last);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= finish;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= zero_op ? DONE : RUN;
            ready <= zero_op;
            busy  <= !zero_op;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else if (last) begin
            state <= DONE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_mul_shift_add.sv
// Shift-and-add sequential multiplier, one multiplier bit per cycle with early exit.
// Define SEQ_MUL_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned loop).
module seq_mul_shift_add
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    result;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             zero_op;
  logic             last;
  logic             load;
  logic             step;
  logic             finish;

`ifdef SEQ_MUL_SIGNED_EN
  logic neg;

  // Negating the most-negative value wraps to itself, which is the correct unsigned magnitude.
  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = b[WIDTH-1] ? -b : b;
  assign result = neg ? -acc_next : acc_next;
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = acc_next;
`endif

  assign zero_op  = (a == '0) || (b == '0);
  assign acc_next = mplier[0] ? acc + mcand : acc;
  assign last     = (mplier[WIDTH-1:1] == '0);

  seq_mul_ctrl u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .zero_op (zero_op),
    .last    (last),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .load    (load),
    .step    (step),
    .finish  (finish)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      product <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      if (load) begin
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
        acc    <= '0;
`ifdef SEQ_MUL_SIGNED_EN
        neg    <= a[WIDTH-1] ^ b[WIDTH-1];
`endif
      end else if (step) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      // The zero-operand shortcut finishes on the accept edge and forces a clean 0.
      if (finish) product <= load ? '0 : result;
    end
  end

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Directed and random checks for seq_mul_shift_add (W=4 and W=8 instances).
module tb_seq_mul_shift_add;
  import seq_mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, abort4, ready4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;
  logic        start8, abort8, ready8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_mul_shift_add #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .done(done4), .product(product4)
  );

  seq_mul_shift_add #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .product(product8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits from the cycle after an accept edge; returns edges until done is seen.
  // A done raised by the accept edge itself (zero shortcut) reports 1.
  task automatic wait_done4(input bit keep_start, output int lat);
    int e = 0;
    forever begin
      @(negedge clk);
      if (!keep_start) start4 = 1'b0;
      if (done4 || e >= 40) break;
      e++;
    end
    lat = (e == 0) ? 1 : e;
  endtask

  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] exp_prod, input int exp_lat);
    int lat;
    @(negedge clk);
    a4 = a; b4 = b; start4 = 1'b1;
    wait_done4(1'b0, lat);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " product"}, 64'(product4), 64'(exp_prod));
    @(negedge clk);
    check({tag, " done pulse"}, 64'(done4), 64'd0);
    check({tag, " ready"}, 64'(ready4), 64'd1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b);
    int e = 0;
    int lat, ia, ib, am, bm;
    logic signed [7:0] sa, sb;
    logic [15:0] exp_prod;
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    forever begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8 || e >= 40) break;
      e++;
    end
    lat = (e == 0) ? 1 : e;
`ifdef SEQ_MUL_SIGNED_EN
    sa = a; sb = b;
    ia = int'(sa); ib = int'(sb);
    am = (ia < 0) ? -ia : ia;
    bm = (ib < 0) ? -ib : ib;
    exp_prod = 16'(ia * ib);
`else
    sa = '0; sb = '0;
    ia = int'(a); ib = int'(b);
    am = ia; bm = ib;
    exp_prod = 16'(ia * ib);
`endif
    check($sformatf("rand %0h*%0h product", a, b), 64'(product8), 64'(exp_prod));
    check($sformatf("rand %0h*%0h latency", a, b), 64'(lat),
          64'(expected_latency(32'(am), 32'(bm))));
  endtask

  initial begin
    int lat;
    bit seen;
    logic [7:0] ra, rb;

    rst_n = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; abort8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    check("reset ready", 64'(ready4), 64'd1);
    check("reset busy", 64'(busy4), 64'd0);
    check("reset done", 64'(done4), 64'd0);
    check("reset product", 64'(product4), 64'd0);
    check("reset ready w8", 64'(ready8), 64'd1);
    rst_n = 1'b1;

`ifdef SEQ_MUL_SIGNED_EN
    run4("s -3*5", 4'hD, 4'h5, 8'hF1, 3);
    run4("s -8*-8", 4'h8, 4'h8, 8'h40, 4);
    run4("s -8*7", 4'h8, 4'h7, 8'hC8, 3);
    run4("s 0*-1", 4'h0, 4'hF, 8'h00, 1);
`else
    // 5*3: busy right after accept, then done two cycles after accept.
    @(negedge clk);
    a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("5*3 busy", 64'(busy4), 64'd1);
    check("5*3 ready low", 64'(ready4), 64'd0);
    @(negedge clk);
    check("5*3 not done yet", 64'(done4), 64'd0);
    @(negedge clk);
    check("5*3 done", 64'(done4), 64'd1);
    check("5*3 product", 64'(product4), 64'd15);
    @(negedge clk);
    check("5*3 done pulse", 64'(done4), 64'd0);
    check("5*3 ready", 64'(ready4), 64'd1);
    run4("15*15", 4'd15, 4'd15, 8'd225, 4);
    run4("9*0", 4'd9, 4'd0, 8'd0, 1);
    run4("0*6", 4'd0, 4'd6, 8'd0, 1);
    run4("1*8", 4'd1, 4'd8, 8'd8, 4);
`endif

    // Back-to-back with start held: the changed operands during RUN must be ignored.
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd2; start4 = 1'b1;
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd1;
    wait_done4(1'b1, lat);
    check("b2b first latency", 64'(lat + 1), 64'd2);
    check("b2b first product", 64'(product4), 64'd6);
    wait_done4(1'b0, lat);
    check("b2b second latency", 64'(lat), 64'd1);
    check("b2b second product", 64'(product4), 64'd7);
    @(negedge clk);
    check("b2b done pulse", 64'(done4), 64'd0);

    // Abort (with a competing start) on the 2nd RUN cycle of 6*8.
    @(negedge clk);
    a4 = 4'd6; b4 = 4'd8; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    abort4 = 1'b1; start4 = 1'b1; a4 = 4'd2; b4 = 4'd2;
    @(negedge clk);
    abort4 = 1'b0; start4 = 1'b0;
    check("abort ready", 64'(ready4), 64'd1);
    check("abort busy", 64'(busy4), 64'd0);
    check("abort product held", 64'(product4), 64'd7);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= done4;
    end
    check("abort no done", 64'(seen), 64'd0);

    // Reset mid-RUN discards the operation.
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst mid-run product", 64'(product4), 64'd0);
    check("rst mid-run ready", 64'(ready4), 64'd1);
    check("rst mid-run busy", 64'(busy4), 64'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen |= done4;
    end
    check("rst mid-run no done", 64'(seen), 64'd0);

    // Reset and start together: reset wins.
    @(negedge clk);
    rst_n = 1'b0; a4 = 4'd3; b4 = 4'd3; start4 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start4 = 1'b0;
    check("rst+start busy", 64'(busy4), 64'd0);
    check("rst+start ready", 64'(ready4), 64'd1);
    @(negedge clk);
    check("rst+start no done", 64'(done4), 64'd0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) ra = 8'd0;
      if ($urandom_range(0, 15) == 0) rb = 8'd0;
      if ($urandom_range(0, 15) == 0) rb = 8'h80;
      run8(ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_mul_shift_add.md
Name: seq_mul_shift_add

Overview:
- Parametrised shift-and-add sequential multiplier. It is the next generation of the team's 4-bit repeated-addition seq_mul datapath.
- Controller and datapath are folded behind one start/ready/done handshake.
- Processes one multiplier bit per cycle and exits early once the remaining multiplier bits are zero.
- Sits under the seq_mul UVM environment as the DUT. An optional signed mode is selected by macro.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..32); product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; accepted only on an edge where ready=1.
- abort  input  1  cancels an operation in RUN; ignored elsewhere.
- a  input  WIDTH  multiplicand, sampled on the accept edge.
- b  input  WIDTH  multiplier, sampled on the accept edge.
- ready  output  1  high in IDLE and DONE (block can accept start).
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; product is valid from this cycle onward.
- product  output  2*WIDTH  result register; held until the next done.

Behaviour:
- One clock, clk. Reset is synchronous and active-low (rst_n).
  - On any edge with rst_n=0: state=IDLE, product=0, done=0, busy=0, ready=1, internal regs=0.
  - Reset asserted mid-operation discards the operation; no done is produced.
- FSM states: IDLE, RUN, DONE.
- Accept edge (start=1 while IDLE or DONE):
  - mcand <= zero-extended a (2*WIDTH wide); mplier <= b; acc <= 0.
  - If a==0 or b==0: go straight to DONE, with product <= 0.
  - Otherwise go to RUN.
- Each RUN edge:
  - if mplier[0]=1, acc <= acc + mcand (modulo 2^(2*WIDTH); the true product never overflows);
  - mcand <= mcand << 1; mplier <= mplier >> 1.
  - If (mplier >> 1)==0: go to DONE and load product <= acc_next on the same edge.
- RUN therefore lasts k cycles, where k = index of the highest set bit of b, plus 1.
- Latency from the accept edge to done high is k cycles. The operand==0 case takes 1 cycle. Worst case is WIDTH cycles.
- DONE lasts exactly one cycle with done=1.
  - Next state is IDLE, or RUN/DONE if start is accepted in that same cycle (back-to-back; done still pulses).
- start while in RUN is ignored (not queued).
- abort=1 in RUN: next state is IDLE, product unchanged, no done.
  - abort and start together in RUN: abort wins, start is ignored.
- Simultaneous rst_n=0 and start: reset wins.
- a and b may change freely after the accept edge.

Optional Feature:
- Macro SEQ_MUL_SIGNED_EN.
- Defined: a and b are two's complement.
  - On the accept edge the block latches |a|, |b| and neg = a[MSB]^b[MSB], then runs the same unsigned loop.
  - The edge entering DONE loads product <= neg ? -acc_next : acc_next.
  - Zero-operand shortcut gives product 0 (never -0 artefacts).
  - Most-negative operands are legal: for W=4, -8*-8=64 and -8*7=-56.
  - Latency is computed from |b|.
- Undefined: operands are unsigned, there is no sign logic, and the ports are identical.

Decomposition:
- Package seq_mul_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - the default WIDTH localparam;
  - a function computing the expected latency, for the scoreboard.
- One natural sub-module, seq_mul_ctrl: the FSM, producing ready/busy/done/load/step/finish.
- Registers and adder stay in seq_mul_shift_add.

Test Plan:
- Unsigned W=4, a=5, b=3 -> RUN 2 cycles, done pulses 2 cycles after accept, product=15, ready back high.
- a=15, b=15 (W=4) -> 4 RUN cycles, product=225; then a=9, b=0 -> done 1 cycle after accept, product=0.
- Back-to-back: start held high; a=3, b=2 then a=7, b=1 accepted in the DONE cycle -> two done pulses, products 6 then 7.
- Abort: a=6, b=8, abort on the 2nd RUN cycle -> IDLE, no done, product keeps its previous value. Separately, rst_n=0 mid-RUN -> product=0, ready=1.
- SEQ_MUL_SIGNED_EN, W=4:
  - a=-3, b=5 -> -15 (8'hF1);
  - a=-8, b=-8 -> 64;
  - a=-8, b=7 -> -56;
  - a=0, b=-1 -> 0.
- Random W=8, 1000 operations -> product matches a*b, and latency matches the seq_mul_pkg function.
